flow_task_sched: RTL and testbench
==================================

# flow_task_sched

Per-flow packet task scheduler sitting directly upstream of the packet generator. It holds a configuration entry per flow: enable, packet size and, optionally, a packet quota. It arbitrates round-robin among eligible flows and issues one packet task at a time over a valid/ready handshake. The generator asserts ready on the cycle it emits the packet's final word.

## Interface
Parameters:
- FLOW_CNT, 16, number of flows.
- FLOW_CNT_WIDTH, (FLOW_CNT==1) ? 1 : $clog2(FLOW_CNT), flow index width.
- MIN_PKT_SIZE, 60, lower clamp for issued size in bytes.
- MAX_PKT_SIZE, 9600, upper clamp for issued size in bytes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cfg_wr_i  in  1  one-cycle config write strobe.
- cfg_flow_i  in  FLOW_CNT_WIDTH  flow index written.
- cfg_en_i  in  1  flow enable.
- cfg_size_i  in  16  packet size in bytes.
- cfg_pkt_cnt_i  in  32  packet quota, 0 = unlimited. Port exists only with FLOW_TASK_SCHED_QUOTA_EN.
- task_flow_num_o  out  FLOW_CNT_WIDTH  flow of current task.
- task_size_o  out  16  clamped byte size of current task.
- task_valid_o  out  1  task offered.
- task_ready_i  in  1  task consumed; sampled only while task_valid_o=1.
- flow_done_o  out  FLOW_CNT  quota exhausted per flow. Port exists only with FLOW_TASK_SCHED_QUOTA_EN.

## Operation
- Per-flow registers: en, size[15:0]; with the macro, also limited, remain[31:0] and done.
- Config write: cfg_wr_i=1 overwrites the entry for cfg_flow_i in the same cycle.
  - en = cfg_en_i.
  - size = cfg_size_i.
  - limited = (cfg_pkt_cnt_i != 0).
  - remain = cfg_pkt_cnt_i.
  - done = 0.
  - A write to an out-of-range index (cfg_flow_i ≥ FLOW_CNT) is ignored.
- Eligibility: a flow is eligible when en=1. With the macro, the flow must also satisfy !(limited && remain==0).
- FSM has two states: IDLE and ISSUE.
  - IDLE: if any flow is eligible, latch the winner's index and clamped size, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: task_valid_o=1 and the outputs are held stable. When task_ready_i=1:
    - store last_grant = task_flow_num_o;
    - with the macro and limited=1, decrement remain; if remain goes 1→0, set done;
    - go to IDLE.
- Round-robin order: search starts at (last_grant+1) mod FLOW_CNT and wraps. The first eligible flow in that order wins. last_grant resets to FLOW_CNT-1, so flow 0 has first priority after reset.
- Clamp: the latched size is max(MIN_PKT_SIZE, min(MAX_PKT_SIZE, size)). The clamp is applied at latch time.
- A config write to the flow currently in ISSUE does not alter the latched task. Disabling that flow, or rewriting its quota, does not retract valid. The new values take effect from the next arbitration. A quota rewrite in the same cycle as the handshake wins over the decrement.
- Quota counter never wraps below 0.

## Timing
- Reset values:
  - task_valid_o=0, task_flow_num_o=0, task_size_o=0, flow_done_o=0.
  - All entries: en=0, size=0, limited=0, remain=0.
  - FSM in IDLE.
- Arbitration latency:
  - task_valid_o rises one cycle after the cycle in which IDLE sees an eligible flow.
  - A flow enabled by a write in cycle N is seen in IDLE at N+1 and offered at N+2.
- After the handshake cycle there is exactly one IDLE bubble cycle (valid=0) before the next task. A task is at most every 2 cycles.
- Outputs are registered; there is no combinational path from task_ready_i or cfg_* to any output.
- Reset asserted mid-task drops valid immediately (asynchronous) and clears all state.

## Configuration
- Macro: FLOW_TASK_SCHED_QUOTA_EN.
- Defined: per-flow 32-bit quota, with the cfg_pkt_cnt_i and flow_done_o ports. A flow stops being scheduled after exactly cfg_pkt_cnt_i tasks (0 = unlimited).
- Not defined: these ports and the limited/remain/done registers are absent. Every enabled flow is scheduled indefinitely.

## Test plan
- Reset, no writes, ready held 1 for 50 cycles -> task_valid_o stays 0 and all outputs stay 0.
- Enable flows 0, 3, 5 with sizes 64/128/256, ready always 1 -> tasks issue in order 0,3,5,0,3,5… with sizes 64/128/256. Valid is high every other cycle.
- Flow 2 size 10 and flow 4 size 20000 -> task_size_o=60 and 9600 respectively.
- Flow 1 in ISSUE, ready held 0 for 8 cycles while flow 1 is rewritten with en=0 and size=500 -> valid and size stay unchanged until ready. After ready, flow 1 is never offered again.
- (Macro defined) Flow 6 quota 3, flow 7 unlimited -> flow 6 is issued exactly 3 times. flow_done_o[6] rises in the cycle after the third handshake. Flow 7 continues alone, back-to-back every 2 cycles.
- Assert rst_i for 1 cycle mid-ISSUE -> valid drops asynchronously and flow_done_o clears. Nothing is issued until a new enable write.

Source files
------------

// File: rtl/flow_task_sched_if.sv
// Config and task-handshake bundle for flow_task_sched.
// Quota signals exist only when FLOW_TASK_SCHED_QUOTA_EN is defined.
interface flow_task_sched_if #(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
);
    logic                      cfg_wr_i;
    logic [FLOW_CNT_WIDTH-1:0] cfg_flow_i;
    logic                      cfg_en_i;
    logic [15:0]               cfg_size_i;
`ifdef FLOW_TASK_SCHED_QUOTA_EN
    logic [31:0]               cfg_pkt_cnt_i;
    logic [FLOW_CNT-1:0]       flow_done_o;
`endif
    logic [FLOW_CNT_WIDTH-1:0] task_flow_num_o;
    logic [15:0]               task_size_o;
    logic                      task_valid_o;
    logic                      task_ready_i;

    // master: host/generator side; slave: the scheduler
    modport master (
        output cfg_wr_i, cfg_flow_i, cfg_en_i, cfg_size_i,
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        output cfg_pkt_cnt_i,
        input  flow_done_o,
`endif
        output task_ready_i,
        input  task_flow_num_o, task_size_o, task_valid_o
    );
    modport slave (
        input  cfg_wr_i, cfg_flow_i, cfg_en_i, cfg_size_i,
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        input  cfg_pkt_cnt_i,
        output flow_done_o,
`endif
        input  task_ready_i,
        output task_flow_num_o, task_size_o, task_valid_o
    );
endinterface

// File: rtl/flow_task_sched.sv
// Round-robin per-flow packet task scheduler feeding the packet generator.
// Optional per-flow packet quota under FLOW_TASK_SCHED_QUOTA_EN.
module flow_task_sched_entry (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic        en_i,
    input  logic [15:0] size_i,
`ifdef FLOW_TASK_SCHED_QUOTA_EN
    input  logic [31:0] pkt_cnt_i,
    input  logic        dec_i,
    output logic        done_o,
`endif
    output logic [15:0] size_o,
    output logic        elig_o
);
    logic en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en     <= 1'b0;
            size_o <= '0;
        end else if (wr_i) begin
            en     <= en_i;
            size_o <= size_i;
        end
    end

`ifdef FLOW_TASK_SCHED_QUOTA_EN
    logic        limited;
    logic [31:0] remain;

    // A rewrite in the handshake cycle takes priority over the decrement
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            limited <= 1'b0;
            remain  <= '0;
            done_o  <= 1'b0;
        end else if (wr_i) begin
            limited <= (pkt_cnt_i != '0);
            remain  <= pkt_cnt_i;
            done_o  <= 1'b0;
        end else if (dec_i && limited && remain != '0) begin
            remain <= remain - 32'd1;
            if (remain == 32'd1) done_o <= 1'b1;
        end
    end

    assign elig_o = en && !(limited && remain == '0);
`else
    assign elig_o = en;
`endif
endmodule

module flow_task_sched #(
    parameter int FLOW_CNT       = 16,
    parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
    parameter int MIN_PKT_SIZE   = 60,
    parameter int MAX_PKT_SIZE   = 9600
) (
    input  logic              clk_i,
    input  logic              rst_i,
    flow_task_sched_if.slave  bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                      state;
    logic [FLOW_CNT_WIDTH-1:0]   last_grant;
    logic [FLOW_CNT_WIDTH-1:0]   task_flow;
    logic [15:0]                 task_size;
    logic                        task_valid;
    logic [FLOW_CNT-1:0]         elig_v;
    logic [FLOW_CNT-1:0][15:0]   size_v;
    logic                        hs;

    assign hs = (state == ISSUE) && bus.task_ready_i;

`ifdef FLOW_TASK_SCHED_QUOTA_EN
    logic [FLOW_CNT-1:0] done_v;
    assign bus.flow_done_o = done_v;
`endif

    for (genvar g = 0; g < FLOW_CNT; g++) begin : g_flow
        // Out-of-range indices match no entry, so such writes fall away
        flow_task_sched_entry u_entry (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_i      (bus.cfg_wr_i && (bus.cfg_flow_i == FLOW_CNT_WIDTH'(g))),
            .en_i      (bus.cfg_en_i),
            .size_i    (bus.cfg_size_i),
`ifdef FLOW_TASK_SCHED_QUOTA_EN
            .pkt_cnt_i (bus.cfg_pkt_cnt_i),
            .dec_i     (hs && (task_flow == FLOW_CNT_WIDTH'(g))),
            .done_o    (done_v[g]),
`endif
            .size_o    (size_v[g]),
            .elig_o    (elig_v[g])
        );
    end

    logic                      win_found;
    logic [FLOW_CNT_WIDTH-1:0] win_idx;
    logic [FLOW_CNT_WIDTH-1:0] scan_idx;
    logic [15:0]               win_size;
    logic [15:0]               win_clamped;

    // Search starts just after the last grant and wraps once around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= FLOW_CNT; i++) begin
            scan_idx = FLOW_CNT_WIDTH'((int'(last_grant) + i) % FLOW_CNT);
            if (!win_found && elig_v[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_size = size_v[win_idx];
        if (win_size < 16'(MIN_PKT_SIZE))      win_clamped = 16'(MIN_PKT_SIZE);
        else if (win_size > 16'(MAX_PKT_SIZE)) win_clamped = 16'(MAX_PKT_SIZE);
        else                                   win_clamped = win_size;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            task_valid <= 1'b0;
            task_flow  <= '0;
            task_size  <= '0;
            last_grant <= FLOW_CNT_WIDTH'(FLOW_CNT - 1);
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    task_flow  <= win_idx;
                    task_size  <= win_clamped;
                    task_valid <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: if (hs) begin
                    last_grant <= task_flow;
                    task_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.task_flow_num_o = task_flow;
    assign bus.task_size_o     = task_size;
    assign bus.task_valid_o    = task_valid;
endmodule

// File: tb/tb_flow_task_sched.sv
// Randomized bench for flow_task_sched against a transaction-level scheduler model.
module tb_flow_task_sched;
    localparam int FC   = 12;
    localparam int FW   = 4;
    localparam int MINS = 60;
    localparam int MAXS = 9600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flow_task_sched_if #(.FLOW_CNT(FC)) bus();
    flow_task_sched #(.FLOW_CNT(FC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: per-flow config plus the one outstanding task
    bit          m_en[FC];
    int          m_size[FC];
    bit          m_lim[FC];
    int unsigned m_rem[FC];
    bit          m_done[FC];
    int          m_last;
    bit          m_busy;
    int          m_flow;
    int          m_tsz;
    int          dut_f6;

    function automatic int clampsz(int s);
        if (s < MINS) return MINS;
        if (s > MAXS) return MAXS;
        return s;
    endfunction

    function automatic bit elig(int f);
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        return m_en[f] && !(m_lim[f] && m_rem[f] == 0);
`else
        return m_en[f];
`endif
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < FC; f++) begin
            m_en[f] = 0; m_size[f] = 0; m_lim[f] = 0; m_rem[f] = 0; m_done[f] = 0;
        end
        m_last = FC - 1;
        m_busy = 0;
        m_flow = 0;
        m_tsz  = 0;
    endfunction

    task automatic cycle();
        logic [FC-1:0] ed;
        @(negedge clk);
        chk("valid", 32'(bus.task_valid_o), 32'(m_busy));
        if (m_busy) begin
            chk("flow", 32'(bus.task_flow_num_o), m_flow);
            chk("size", 32'(bus.task_size_o), m_tsz);
        end
        for (int f = 0; f < FC; f++) ed[f] = m_done[f];
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        chk("done", 32'(bus.flow_done_o), 32'(ed));
`endif
        if (bus.task_valid_o && bus.task_ready_i && bus.task_flow_num_o == FW'(6)) dut_f6++;
        if (!m_busy) begin
            for (int i = 1; i <= FC; i++) begin
                int f = (m_last + i) % FC;
                if (elig(f)) begin
                    m_busy = 1; m_flow = f; m_tsz = clampsz(m_size[f]);
                    break;
                end
            end
        end else if (bus.task_ready_i) begin
            m_last = m_flow;
            m_busy = 0;
            if (m_lim[m_flow] && m_rem[m_flow] > 0) begin
                m_rem[m_flow]--;
                if (m_rem[m_flow] == 0) m_done[m_flow] = 1;
            end
        end
        if (bus.cfg_wr_i && int'(bus.cfg_flow_i) < FC) begin
            m_en[bus.cfg_flow_i]   = bus.cfg_en_i;
            m_size[bus.cfg_flow_i] = int'(bus.cfg_size_i);
`ifdef FLOW_TASK_SCHED_QUOTA_EN
            m_lim[bus.cfg_flow_i]  = (bus.cfg_pkt_cnt_i != 0);
            m_rem[bus.cfg_flow_i]  = bus.cfg_pkt_cnt_i;
            m_done[bus.cfg_flow_i] = 0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int f, input bit en, input int sz, input int q);
        bus.cfg_wr_i   = 1'b1;
        bus.cfg_flow_i = FW'(f);
        bus.cfg_en_i   = en;
        bus.cfg_size_i = 16'(sz);
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        bus.cfg_pkt_cnt_i = q;
`else
        if (q < 0) bus.cfg_en_i = 1'b0;
`endif
    endtask

    task automatic wr(input int f, input bit en, input int sz, input int q);
        set_cfg(f, en, sz, q);
        cycle();
        bus.cfg_wr_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!bus.task_valid_o && k < 10) begin
            cycle();
            k++;
        end
        chk(tag, 32'(bus.task_valid_o), 32'd1);
    endtask

    int sizes[6] = '{10, 59, 64, 1500, 9601, 20000};

    initial begin
        rst = 1'b1;
        bus.cfg_wr_i = 1'b0; bus.cfg_flow_i = '0; bus.cfg_en_i = 1'b0; bus.cfg_size_i = '0;
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        bus.cfg_pkt_cnt_i = '0;
`endif
        bus.task_ready_i = 1'b0;
        dut_f6 = 0;
        model_reset();
        #12;
        chk("rst_valid", 32'(bus.task_valid_o), 0);
        chk("rst_flow", 32'(bus.task_flow_num_o), 0);
        chk("rst_size", 32'(bus.task_size_o), 0);
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        chk("rst_done", 32'(bus.flow_done_o), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // idle with ready high
        bus.task_ready_i = 1'b1;
        repeat (50) cycle();

        // basic round robin and clamping
        wr(0, 1, 64, 0); wr(3, 1, 128, 0); wr(5, 1, 256, 0);
        repeat (20) cycle();
        wr(2, 1, 10, 0); wr(4, 1, 20000, 0);
        repeat (24) cycle();

        // hold flow 1 in ISSUE while it is rewritten
        for (int f = 0; f < 6; f++) wr(f, 0, 0, 0);
        repeat (4) cycle();
        bus.task_ready_i = 1'b0;
        wr(1, 1, 100, 0);
        wait_valid("hold_offer");
        chk("hold_flow", 32'(bus.task_flow_num_o), 1);
        wr(1, 0, 500, 0);
        repeat (7) cycle();
        chk("hold_size", 32'(bus.task_size_o), 100);
        bus.task_ready_i = 1'b1;
        repeat (10) cycle();

`ifdef FLOW_TASK_SCHED_QUOTA_EN
        // quota: flow 6 three packets, flow 7 unlimited
        dut_f6 = 0;
        wr(6, 1, 70, 3); wr(7, 1, 80, 0);
        repeat (30) cycle();
        chk("f6_count", dut_f6, 3);
        chk("f6_done", 32'(bus.flow_done_o[6]), 1);
        wr(6, 0, 0, 0); wr(7, 0, 0, 0);
        repeat (4) cycle();
`endif

        // random traffic, including out-of-range indices and small quotas
        repeat (600) begin
            bus.task_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                set_cfg($urandom_range(0, 15), ($urandom_range(0, 4) != 0),
                        sizes[$urandom_range(0, 5)], $urandom_range(0, 3));
            cycle();
            bus.task_ready_i = 1'b0;
            bus.cfg_wr_i = 1'b0;
        end

        // reset mid-ISSUE
        for (int f = 0; f < FC; f++) wr(f, 0, 0, 0);
        bus.task_ready_i = 1'b1;
        repeat (4) cycle();
        bus.task_ready_i = 1'b0;
        wr(0, 1, 64, 2);
        wait_valid("pre_rst_offer");
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus.task_valid_o), 0);
`ifdef FLOW_TASK_SCHED_QUOTA_EN
        chk("async_done", 32'(bus.flow_done_o), 0);
`endif
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.task_ready_i = 1'b1;
        repeat (10) cycle();
        wr(3, 1, 64, 0);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
